// File: rtl/zoom_pkg.sv
// Shared definitions for the zoom line buffer: default widths, sizing helper
// and error flag bit positions.
package zoom_pkg;

   localparam int unsigned DATA_W_DEF = 24;
   localparam int unsigned ADDR_W_DEF = 11;

   localparam int unsigned ERR_OVF = 0;
   localparam int unsigned ERR_LEN = 1;

   // Ceiling log2, used to size line pointers and the commit counter.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/zoom_line_ram.sv
// One video line of storage: simple dual-port RAM with a registered read and an
// optional extra output register.
// Ports: clk, rst_n; write port we/waddr/wdata; read port re/raddr -> rdata.
module zoom_line_ram #(
   parameter int unsigned DATA_W  = 24,
   parameter int unsigned ADDR_W  = 11,
   parameter int unsigned OUT_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] q1;

   // Storage array: not reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read register: resets to 0 so the outputs start clean.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q1 <= '0;
      else if (re) q1 <= mem[raddr];
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [DATA_W-1:0] q2;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) q2 <= '0;
            else        q2 <= q1;
         end
         assign rdata = q2;
      end else begin : g_noreg
         assign rdata = q1;
      end
   endgenerate

endmodule

// File: rtl/zoom_line_buffer.sv
// Multi-line ring buffer feeding the vertical interpolator: writes whole lines
// into slots, serves the top line and the line below it per read, replicating
// the top line when only one line is committed.
// Ports: clk, rst_n, sof; write side wr_vld/wr_data/wr_eol/wr_rdy; read side
// rd_en/rd_x/rd_release -> rd_data0/rd_data1/rd_vld; lines_avail; err (sticky).
module zoom_line_buffer
   import zoom_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned N_LINES = 4,
   parameter int unsigned OUT_REG = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sof,
   input  logic                       wr_vld,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       wr_eol,
   output logic                       wr_rdy,
   input  logic                       rd_en,
   input  logic [ADDR_W-1:0]          rd_x,
   input  logic                       rd_release,
   output logic [DATA_W-1:0]          rd_data0,
   output logic [DATA_W-1:0]          rd_data1,
   output logic                       rd_vld,
   output logic [clog2(N_LINES):0]    lines_avail,
   output logic [1:0]                 err
);

   localparam int unsigned PW    = clog2(N_LINES);
   localparam int unsigned CW    = PW + 1;
   localparam int unsigned DEPTH = (OUT_REG != 0) ? 2 : 1;
   localparam logic [ADDR_W-1:0] COL_MAX = '1;

   logic [PW-1:0]     wr_ptr, rd_ptr, wp_base, rp_base, wr_ptr_n, rd_ptr_n, sel1;
   logic [ADDR_W-1:0] wr_col, wc_base, wr_col_n;
   logic [CW-1:0]     c, c_base, c_n;
   logic [1:0]        err_n;
   logic              can_wr, wr_do, last, commit, rel, rd_acc;

   logic [DATA_W-1:0] ram_q [N_LINES];
   logic              vld_p [DEPTH];
   logic [PW-1:0]     s0_p  [DEPTH];
   logic [PW-1:0]     s1_p  [DEPTH];

   // Next-state for pointers, column, commit count and error flags.
   // sof clears state first; a same-cycle write then applies on the cleared state.
   always_comb begin
      wp_base  = sof ? '0 : wr_ptr;
      rp_base  = sof ? '0 : rd_ptr;
      wc_base  = sof ? '0 : wr_col;
      c_base   = sof ? '0 : c;
      can_wr   = sof | wr_rdy;
      wr_do    = wr_vld & can_wr;
      last     = (wc_base == COL_MAX);
      commit   = wr_do & (wr_eol | last);
      rel      = rd_release & (c_base != '0);
      rd_acc   = rd_en & (c != '0) & ~sof;
      wr_ptr_n = wp_base + PW'(commit);
      rd_ptr_n = rp_base + PW'(rel);
      wr_col_n = commit ? '0 : wc_base + ADDR_W'(wr_do);
      c_n      = c_base + CW'(commit) - CW'(rel);
      sel1     = (c >= CW'(2)) ? rd_ptr + PW'(1) : rd_ptr;
      err_n    = err;
      if (wr_vld & ~can_wr)           err_n[ERR_OVF] = 1'b1;
      if (wr_do & last & ~wr_eol)     err_n[ERR_LEN] = 1'b1;
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         wr_col <= '0;
         c      <= '0;
         wr_rdy <= 1'b1;
         err    <= '0;
      end else begin
         wr_ptr <= wr_ptr_n;
         rd_ptr <= rd_ptr_n;
         wr_col <= wr_col_n;
         c      <= c_n;
         wr_rdy <= (c_n < CW'(N_LINES));
         err    <= err_n;
      end
   end

   // Read pipeline: valid and slot selects travel alongside the RAM latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            vld_p[i] <= 1'b0;
            s0_p[i]  <= '0;
            s1_p[i]  <= '0;
         end
      end else begin
         vld_p[0] <= rd_acc;
         if (rd_acc) begin
            s0_p[0] <= rd_ptr;
            s1_p[0] <= sel1;
         end
         for (int i = 1; i < int'(DEPTH); i++) begin
            vld_p[i] <= vld_p[i-1];
            s0_p[i]  <= s0_p[i-1];
            s1_p[i]  <= s1_p[i-1];
         end
      end
   end

   generate
      for (genvar g = 0; g < int'(N_LINES); g++) begin : g_line
         zoom_line_ram #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .OUT_REG (OUT_REG)
         ) u_ram (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (wr_do && (wp_base == PW'(g))),
            .waddr (wc_base),
            .wdata (wr_data),
            .re    (rd_acc),
            .raddr (rd_x),
            .rdata (ram_q[g])
         );
      end
   endgenerate

   assign rd_vld      = vld_p[DEPTH-1];
   assign rd_data0    = ram_q[s0_p[DEPTH-1]];
   assign rd_data1    = ram_q[s1_p[DEPTH-1]];
   assign lines_avail = c;

endmodule

// File: tb/tb_zoom_line_buffer.sv
// Directed bench for zoom_line_buffer (DATA_W=24, ADDR_W=11, N_LINES=4, OUT_REG=1).
module tb_zoom_line_buffer;

   bit          clk = 1'b0;
   logic        rst_n;
   logic        sof;
   logic        wr_vld;
   logic [23:0] wr_data;
   logic        wr_eol;
   logic        wr_rdy;
   logic        rd_en;
   logic [10:0] rd_x;
   logic        rd_release;
   logic [23:0] rd_data0;
   logic [23:0] rd_data1;
   logic        rd_vld;
   logic [2:0]  lines_avail;
   logic [1:0]  err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   zoom_line_buffer #(
      .DATA_W  (24),
      .ADDR_W  (11),
      .N_LINES (4),
      .OUT_REG (1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sof         (sof),
      .wr_vld      (wr_vld),
      .wr_data     (wr_data),
      .wr_eol      (wr_eol),
      .wr_rdy      (wr_rdy),
      .rd_en       (rd_en),
      .rd_x        (rd_x),
      .rd_release  (rd_release),
      .rd_data0    (rd_data0),
      .rd_data1    (rd_data1),
      .rd_vld      (rd_vld),
      .lines_avail (lines_avail),
      .err         (err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Writes one line of len pixels valued {id, col}; optional release on the eol cycle.
   task automatic wr_line(input int id, input int len, input bit rel_on_eol);
      for (int col = 0; col < len; col++) begin
         wr_vld     = 1'b1;
         wr_data    = {8'(id), 16'(col)};
         wr_eol     = (col == len - 1);
         rd_release = rel_on_eol && (col == len - 1);
         tick();
      end
      wr_vld     = 1'b0;
      wr_eol     = 1'b0;
      rd_release = 1'b0;
   endtask

   // Single read; returns after the cycle in which rd_vld is expected.
   task automatic rd_issue(input int x);
      rd_en = 1'b1;
      rd_x  = 11'(x);
      tick();
      rd_en = 1'b0;
      tick();
   endtask

   task automatic rd_check(input string tag, input int x, input logic [23:0] e0,
                           input logic [23:0] e1);
      rd_issue(x);
      chk(tag, 64'({rd_vld, rd_data0, rd_data1}), 64'({1'b1, e0, e1}));
   endtask

   task automatic release_one();
      rd_release = 1'b1;
      tick();
      rd_release = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; sof = 1'b0; wr_vld = 1'b0; wr_data = '0; wr_eol = 1'b0;
      rd_en = 1'b0; rd_x = '0; rd_release = 1'b0;
      tick(); tick();
      chk("rst_lines",  64'(lines_avail), 64'(0));
      chk("rst_wr_rdy", 64'(wr_rdy), 64'(1));
      chk("rst_rd_vld", 64'(rd_vld), 64'(0));
      chk("rst_err",    64'(err), 64'(0));
      chk("rst_data",   64'({rd_data0, rd_data1}), 64'(0));
      rst_n = 1'b1;
      tick();

      // Read with nothing committed is ignored.
      rd_en = 1'b1; rd_x = 11'd3;
      tick();
      rd_en = 1'b0;
      chk("empty_rd_a", 64'(rd_vld), 64'(0));
      tick();
      chk("empty_rd_b", 64'(rd_vld), 64'(0));
      chk("empty_err",  64'(err), 64'(0));

      // Line 0, then bottom-edge replication with a single line.
      wr_line(0, 1920, 1'b0);
      chk("fill_l0", 64'(lines_avail), 64'(1));
      rd_en = 1'b1; rd_x = 11'd5;
      tick();
      rd_en = 1'b0;
      chk("repl_lat_t1", 64'(rd_vld), 64'(0));
      tick();
      chk("repl_x5", 64'({rd_vld, rd_data0, rd_data1}), 64'({1'b1, 24'h000005, 24'h000005}));
      tick();
      chk("repl_vld_drop", 64'(rd_vld), 64'(0));

      // Line 1, paired read and a back-to-back sweep.
      wr_line(1, 1920, 1'b0);
      chk("fill_l1", 64'(lines_avail), 64'(2));
      rd_check("pair_x100", 100, 24'h000064, 24'h010064);
      for (int k = 0; k <= 1920; k++) begin
         rd_en = (k < 1920);
         rd_x  = 11'(k);
         tick();
         if (k >= 1)
            chk("sweep", 64'({rd_vld, rd_data0, rd_data1}),
                64'({1'b1, 8'd0, 16'(k - 1), 8'd1, 16'(k - 1)}));
      end
      rd_en = 1'b0;
      tick();
      chk("sweep_end", 64'(rd_vld), 64'(0));

      // Fill to capacity, then overflow.
      wr_line(2, 1920, 1'b0);
      chk("fill_l2", 64'(lines_avail), 64'(3));
      chk("rdy_l2",  64'(wr_rdy), 64'(1));
      wr_line(3, 1920, 1'b0);
      chk("fill_l3", 64'(lines_avail), 64'(4));
      chk("full_rdy", 64'(wr_rdy), 64'(0));
      wr_vld = 1'b1; wr_data = 24'h040000;
      tick();
      wr_vld = 1'b0;
      chk("ovf_err",   64'(err), 64'(2'b01));
      chk("ovf_lines", 64'(lines_avail), 64'(4));

      // Wrap: two releases, then ten short lines each committed with a same-cycle release.
      release_one();
      release_one();
      chk("rel2_lines", 64'(lines_avail), 64'(2));
      for (int id = 4; id < 14; id++) begin
         wr_line(id, 8, 1'b1);
         chk("wrap_lines", 64'(lines_avail), 64'(2));
         rd_check("wrap_rd", 3, {8'(id - 1), 16'd3}, {8'(id), 16'd3});
      end

      // Release together with a read: the read uses the old top line.
      rd_en = 1'b1; rd_x = 11'd6; rd_release = 1'b1;
      tick();
      rd_en = 1'b0; rd_release = 1'b0;
      tick();
      chk("rel_rd", 64'({rd_vld, rd_data0, rd_data1}), 64'({1'b1, 24'h0C0006, 24'h0D0006}));
      chk("rel_rd_lines", 64'(lines_avail), 64'(1));
      rd_check("rel_repl", 6, 24'h0D0006, 24'h0D0006);

      // Column overrun: 2048 pixels without eol.
      for (int col = 0; col < 2048; col++) begin
         wr_vld  = 1'b1;
         wr_data = {8'd20, 16'(col)};
         wr_eol  = 1'b0;
         tick();
      end
      wr_vld = 1'b0;
      chk("ovr_lines", 64'(lines_avail), 64'(2));
      chk("ovr_err",   64'(err), 64'(2'b11));
      wr_vld = 1'b1; wr_data = 24'hABCDEF; wr_eol = 1'b1;
      tick();
      wr_vld = 1'b0; wr_eol = 1'b0;
      chk("ovr_next_lines", 64'(lines_avail), 64'(3));
      release_one();
      rd_check("ovr_col0", 0, 24'h140000, 24'hABCDEF);
      rd_issue(2047);
      chk("ovr_col2047", 64'({rd_vld, rd_data0}), 64'({1'b1, 24'h1407FF}));

      // sof mid-line with a write and a read in the same cycle.
      wr_vld = 1'b1; wr_data = 24'h1E0000;
      tick();
      wr_data = 24'h1E0001;
      tick();
      sof = 1'b1; wr_data = 24'h5A5A5A; rd_en = 1'b1; rd_x = 11'd0;
      tick();
      sof = 1'b0; wr_vld = 1'b0; rd_en = 1'b0;
      chk("sof_lines", 64'(lines_avail), 64'(0));
      chk("sof_err",   64'(err), 64'(2'b11));
      chk("sof_rdy",   64'(wr_rdy), 64'(1));
      tick();
      chk("sof_rd_drop", 64'(rd_vld), 64'(0));
      wr_vld = 1'b1; wr_data = 24'h111111; wr_eol = 1'b1;
      tick();
      wr_vld = 1'b0; wr_eol = 1'b0;
      chk("sof_commit", 64'(lines_avail), 64'(1));
      rd_check("sof_col0", 0, 24'h5A5A5A, 24'h5A5A5A);
      rd_check("sof_col1", 1, 24'h111111, 24'h111111);

      // Async reset mid-line.
      wr_vld = 1'b1; wr_data = 24'h222222;
      tick();
      wr_vld = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_lines", 64'(lines_avail), 64'(0));
      chk("arst_rdy",   64'(wr_rdy), 64'(1));
      chk("arst_err",   64'(err), 64'(0));
      chk("arst_vld",   64'(rd_vld), 64'(0));
      chk("arst_data",  64'({rd_data0, rd_data1}), 64'(0));
      tick();
      rst_n = 1'b1;
      tick();
      rd_issue(0);
      chk("arst_empty_rd", 64'(rd_vld), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
